// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit arbiter: default byte
//               width, arbiter state encoding and an index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Byte width used by uart_top
  localparam int DEFAULT_DATA_BITS = 8;

  // Arbiter states: waiting for a requester, or serving one packet
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_state_e;

  // Number of bits needed to index n items
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority picker. Returns the first set bit
//               of req, searching upward from rr_ptr with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  // One extra bit so rr_ptr + offset cannot overflow before the modulo fold
  localparam logic [IDX_W:0] C_NUM_REQ = (IDX_W + 1)'(NUM_REQ);

  logic [IDX_W:0] cand;

  // Walk the candidates in rotated order; the first requesting one wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (cand >= C_NUM_REQ) begin
        cand = cand - C_NUM_REQ;
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-atomic round-robin arbiter sharing the uart_top transmit
//               FIFO write port among NUM_REQ byte-stream requesters. A granted
//               requester that stops presenting data for STALL_LIMIT cycles has
//               its packet aborted and is reported through stall_err/err_id.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                           clk_100MHz,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           tx_full,
  output logic                           write_uart,
  output logic [DATA_BITS-1:0]           write_data,
  output logic [idx_w(NUM_REQ)-1:0]      grant_id,
  output logic                           busy,
  output logic                           stall_err,
  output logic [idx_w(NUM_REQ)-1:0]      err_id
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(STALL_LIMIT);

  localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] C_CNT_LIMIT = CNT_W'(STALL_LIMIT - 1);

  arb_state_e       state_q,     state_d;
  logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0] grant_q,     grant_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             stall_err_q, stall_err_d;
  logic [IDX_W-1:0] err_id_q,    err_id_d;

  logic             in_send;
  logic             sel_valid;
  logic             sel_last;
  logic             xfer;
  logic [IDX_W-1:0] next_ptr;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign in_send   = (state_q == ARB_SEND);
  assign sel_valid = req_valid[grant_q];
  assign sel_last  = req_last[grant_q];
  assign xfer      = in_send & sel_valid & ~tx_full;
  // The requester after the current grantee gets first look next time
  assign next_ptr  = (grant_q == C_LAST_IDX) ? '0 : grant_q + IDX_W'(1);

  // Zero-latency lane mux from the granted requester to the FIFO write port
  always_comb begin
    req_ready = '0;
    if (in_send) begin
      req_ready[grant_q] = ~tx_full;
    end
  end

  assign write_uart = xfer;
  assign write_data = req_data[grant_q*DATA_BITS +: DATA_BITS];

  // Next-state logic: arbitration, packet end, stall counting and abort
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    stall_err_d = 1'b0;
    err_id_d    = err_id_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (xfer) begin
          // A transfer always beats the stall limit, even on the limit cycle
          cnt_d = '0;
          if (sel_last) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (cnt_q == C_CNT_LIMIT) begin
          stall_err_d = 1'b1;
          err_id_d    = grant_q;
          state_d     = ARB_IDLE;
          rr_ptr_d    = next_ptr;
        end else if (!sel_valid) begin
          // Only a silent requester counts; FIFO back-pressure holds the count
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      stall_err_q <= 1'b0;
      err_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      stall_err_q <= stall_err_d;
      err_id_q    <= err_id_d;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = in_send;
  assign stall_err = stall_err_q;
  assign err_id    = err_id_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-atomic round-robin arbiter that shares the single transmit-FIFO write port of the UART core (`uart_top`: `write_uart`, `write_data`, `tx_full`) among several byte-stream requesters. It sits between on-chip message sources (echo path, status reporter, debug dumper) and `uart_top`. It grants one requester at a time for a complete packet, so packets from different sources never interleave on the serial line. A requester that stalls mid-packet for too long is aborted and flagged.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `DATA_BITS`, 8: byte width, matching `uart_top`.
- `STALL_LIMIT`, 1024: consecutive cycles without `req_valid` from the granted requester before the packet is aborted. Must be ≥2.

- `clk_100MHz`  in  1: system clock.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NUM_REQ: requester i has a byte on its data lane.
- `req_data`  in  NUM_REQ*DATA_BITS: byte lanes. Lane i is bits [i*8+7 : i*8].
- `req_last`  in  NUM_REQ: the presented byte is the final byte of its packet.
- `req_ready`  out  NUM_REQ: byte accepted this cycle when high together with `req_valid`.
- `tx_full`  in  1: `uart_top` transmit FIFO is full.
- `write_uart`  out  1: push strobe to `uart_top`.
- `write_data`  out  DATA_BITS: byte to push.
- `grant_id`  out  clog2(NUM_REQ): current or most recent grantee.
- `busy`  out  1: a packet is in progress (state SEND).
- `stall_err`  out  1: one-cycle pulse when a packet is aborted.
- `err_id`  out  clog2(NUM_REQ): requester aborted most recently.

## Operation
- The block has two states.
  - IDLE: if any `req_valid` is high, pick the first asserted index searching upward from `rr_ptr` with wrap-around. Register it into `grant_id` and go to SEND. If none is asserted, stay in IDLE.
  - SEND: serve only requester `grant_id`.
- Datapath in SEND is combinational, with zero added latency:
  - `req_ready[g] = !tx_full`; all other `req_ready` are 0.
  - `write_uart = req_valid[g] & !tx_full`.
  - `write_data = req_data[g]`.
- In IDLE, all `req_ready` = 0 and `write_uart` = 0.
- Packet end: a transfer with `req_last[g]` high moves the state to IDLE and sets `rr_ptr = (g+1) mod NUM_REQ`.
- Stall counter:
  - Cleared on entering SEND and on every transfer.
  - Increments each SEND cycle where `req_valid[g]` = 0.
  - Holds when `tx_full` = 1 and `req_valid[g]` = 1. Back-pressure is not a stall.
- Abort: when the counter equals `STALL_LIMIT-1` and no transfer occurs in that cycle:
  - pulse `stall_err`, set `err_id = g`, go to IDLE, set `rr_ptr = (g+1) mod NUM_REQ`.
  - Bytes already pushed remain in the FIFO. There is no truncation marker.
- Simultaneous events:
  - A transfer in the same cycle as counter limit: the transfer wins and the counter clears.
  - A `req_last` transfer in the same cycle as counter limit: normal packet end, no `stall_err`.
- Requests that rise and fall while another requester is granted are not latched. Requesters hold `req_valid` until served.
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `busy` 0, `stall_err` 0, `err_id` 0, stall counter 0. Consequently `write_uart` 0 and `req_ready` all 0.
- Reset mid-packet: the packet is dropped at once with no further `write_uart`. A partial packet already in the FIFO is not recalled.

## Timing
- Arbitration latency: `req_valid` seen in IDLE at cycle n gives `busy` and `req_ready` at cycle n+1. The first push can happen at n+1.
- Throughput in SEND: one byte per cycle while `req_valid[g]` = 1 and `tx_full` = 0.
- Packet end at cycle n puts the block in IDLE at n+1 and a new grant at n+2. This is exactly one dead cycle between packets.
- Abort: decision at cycle n, `stall_err` high during n+1 only, IDLE at n+1.
- `busy` is registered and equals (state == SEND).
- The counter is clog2(STALL_LIMIT) bits wide and never wraps. It saturates at the abort point.

## Structure
- The shared package `uart_pkg` holds:
  - the `DATA_BITS` default;
  - the state enum `{ARB_IDLE, ARB_SEND}`;
  - an `idx_w(n) = clog2(n)` helper constant function.
- One sub-module, `rr_pick`: a combinational rotate-priority picker. Inputs are the `req` vector and `rr_ptr`; outputs are `found` and `idx`. The FSM, counter and lane mux stay in `uart_tx_arbiter`.

## Test plan
- Single requester: req 2 sends packet "A","B","C" (last on "C") with `tx_full` = 0. Expect `write_uart` on 3 consecutive cycles starting one cycle after `req_valid`, `write_data` 0x41/0x42/0x43, `busy` falling the cycle after "C".
- Round-robin fairness: all 4 requesters continuously send 2-byte packets from reset. Expect grant order 0,1,2,3,0 with exactly one idle cycle between packets and no interleaving.
- Back-pressure: during a 4-byte packet, hold `tx_full` = 1 for 2000 cycles. Expect no `write_uart`, no `stall_err`, and the packet completing after `tx_full` drops.
- Stall abort, with `STALL_LIMIT` = 16: req 1 sends one byte then drops `req_valid`. Expect `stall_err` as a one-cycle pulse 16 cycles later, `err_id` = 1, and the next grant going to req 2 if pending.
- Edge and reset: `req_last` transfer on the exact limit cycle gives no `stall_err`. Asserting `reset` mid-packet gives `write_uart` 0 on the next cycle and all outputs at their reset values, with `grant_id` 0.
